// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants used by the divider arbiter.
package cpu_pkg;

    // Sequencing states of the shared-divider arbiter.
    typedef enum logic [1:0] {
        DA_IDLE,
        DA_ISSUE,
        DA_WAIT,
        DA_RESP
    } div_arb_state_t;

    // Quotient returned for a zero divisor. Kept wide and all-ones so that
    // truncating it to any quotient width up to 32 bits leaves all ones.
    localparam logic [31:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at requester `ptr`,
// moves upward and wraps. The result is a one-hot grant, or zero when no
// requester is asking.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Scan offsets 0..NUM_REQ-1 from the pointer; the first active request wins.
    always_comb begin
        // NOTE: every variable is given a default first, so that no path through the block infers a latch.
        grant = '0;
        found = 1'b0;
        for (int s = 0; s < NUM_REQ; s++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] &&
                    ((int'(ptr) + s == j) || (int'(ptr) + s == j + NUM_REQ))) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between NUM_REQ requesters. The block
// arbitrates round-robin and latches the winning operands. It then drives the
// divider's start/finish handshake and returns the quotient over a per-requester
// valid/ready response. A zero divisor is answered directly without using the
// divider. A watchdog aborts the operation if the divider never finishes.
module div_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 8,
    parameter int QUOT_W      = 9,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_dividend_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_divisor_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    input  logic [NUM_REQ-1:0]        rsp_ready_i,
    output logic [QUOT_W-1:0]         rsp_quotient_o,
    output logic                      rsp_err_o,
    output logic                      div_start_o,
    output logic [DATA_W-1:0]         div_dividend_o,
    output logic [DATA_W-1:0]         div_divisor_o,
    input  logic                      div_busy_i,
    input  logic                      div_finish_i,
    input  logic [QUOT_W-1:0]         div_quotient_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    div_arb_state_t      state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, owner_q, grant_idx, next_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [CNT_W-1:0]    wd_cnt_q;
    logic [DATA_W-1:0]   dividend_q, divisor_q, sel_dividend, sel_divisor;
    logic [QUOT_W-1:0]   quot_q;
    logic                err_q;
    logic                accept, div_by_zero, timeout, owner_ready;

    // Busy is only of interest to an external "not busy while idle" check.
    logic unused_busy;
    assign unused_busy = div_busy_i;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid_i),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    // Encode the one-hot grant and select the winner's operands.
    always_comb begin
        grant_idx    = '0;
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                grant_idx    = PTR_W'(k);
                sel_dividend = req_dividend_i[k*DATA_W +: DATA_W];
                sel_divisor  = req_divisor_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign accept      = (state_q == DA_IDLE) && (|grant);
    assign div_by_zero = (sel_divisor == '0);
    assign timeout     = (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    // Only the owner's ready can close the response; rsp_valid_o is one-hot on it.
    assign owner_ready = |(rsp_ready_i & rsp_valid_o);

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: sequential state is updated with <= so that every flop samples values from before the edge.
        if (!reset_ni) state_q <= DA_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; finish takes priority over a coincident watchdog timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DA_IDLE:  if (accept) state_d = div_by_zero ? DA_RESP : DA_ISSUE;
            DA_ISSUE: state_d = DA_WAIT;
            DA_WAIT:  if (div_finish_i || timeout) state_d = DA_RESP;
            DA_RESP:  if (owner_ready) state_d = DA_IDLE;
            default:  state_d = DA_IDLE;
        endcase
    end

    // Operand and result registers, round-robin pointer, owner and watchdog.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            err_q      <= 1'b0;
            wd_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                DA_IDLE: begin
                    if (accept) begin
                        owner_q    <= grant_idx;
                        rr_ptr_q   <= next_ptr;
                        dividend_q <= sel_dividend;
                        divisor_q  <= sel_divisor;
                        if (div_by_zero) begin
                            quot_q <= QUOT_W'(DIV_ZERO_QUOT);
                            err_q  <= 1'b0;
                        end
                    end
                end
                DA_ISSUE: wd_cnt_q <= '0;
                DA_WAIT: begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                    if (div_finish_i) begin
                        quot_q <= div_quotient_i;
                        err_q  <= 1'b0;
                    end else if (timeout) begin
                        quot_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response valid goes only to the owning requester while in RESP.
    always_comb begin
        rsp_valid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rsp_valid_o[k] = (state_q == DA_RESP) && (owner_q == PTR_W'(k));
        end
    end

    assign req_ready_o    = (state_q == DA_IDLE) ? grant : '0;
    assign div_start_o    = (state_q == DA_ISSUE) || (state_q == DA_WAIT);
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign rsp_quotient_o = quot_q;
    assign rsp_err_o      = err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter. It uses a behavioural divider on the
// divider side and per-requester operation queues on the requester side. A
// transaction-level reference predicts grants, the response timing and the
// response values.
module tb_div_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int DATA_W      = 8;
    localparam int QUOT_W      = 9;
    localparam int TIMEOUT_CYC = 32;

    logic                      clk_i = 1'b0;
    logic                      reset_ni;
    logic [NUM_REQ-1:0]        req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [NUM_REQ*DATA_W-1:0] req_dividend_i, req_divisor_i;
    logic [QUOT_W-1:0]         rsp_quotient_o, div_quotient_i;
    logic                      rsp_err_o, div_start_o, div_busy_i, div_finish_i;
    logic [DATA_W-1:0]         div_dividend_o, div_divisor_o;

    div_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .QUOT_W(QUOT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_quotient_o(rsp_quotient_o), .rsp_err_o(rsp_err_o),
        .div_start_o(div_start_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_busy_i(div_busy_i), .div_finish_i(div_finish_i), .div_quotient_i(div_quotient_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------------------------------------------------------- checking
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- stimulus
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

    op_t op_q[NUM_REQ][$];

    bit drop_en    = 1'b0;  // randomly withdraw a pending request for a cycle
    bit rand_rsp   = 1'b0;  // randomly withhold response ready
    int rsp_block  = 0;     // number of RESP cycles with the owner's ready held low
    bit div_hang   = 1'b0;  // divider never finishes
    int hang_pct   = 0;     // percentage of divider starts that hang
    int dm_lat_fix = -1;    // fixed divider latency, or random if negative

    task automatic push_op(input int k, input int a, input int b);
        op_t o;
        o.a = DATA_W'(a);
        o.b = DATA_W'(b);
        op_q[k].push_back(o);
    endtask

    function automatic bit queues_empty();
        for (int k = 0; k < NUM_REQ; k++) if (op_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // ------------------------------------------------------ divider model
    bit dm_run, dm_prev;
    int dm_cnt;
    int dm_starts = 0;

    // Divider: a rising start begins an operation. The quotient and a one-cycle
    // finish follow after a latency. Dropping start aborts the operation.
    always @(negedge clk_i) begin
        if (!reset_ni) begin
            dm_run = 1'b0; dm_prev = 1'b0; dm_cnt = 0;
            div_busy_i = 1'b0; div_finish_i = 1'b0; div_quotient_i = '0;
        end else begin
            div_finish_i = 1'b0;
            if (!div_start_o) begin
                dm_run = 1'b0;
                div_busy_i = 1'b0;
            end else if (dm_run) begin
                if (dm_cnt == 0) begin
                    div_finish_i = 1'b1;
                    div_busy_i   = 1'b0;
                    dm_run       = 1'b0;
                    div_quotient_i = (div_divisor_o == 0) ? '1 :
                        QUOT_W'(32'(div_dividend_o) / 32'(div_divisor_o));
                end else begin
                    dm_cnt--;
                end
            end else if (!dm_prev) begin
                dm_starts++;
                div_busy_i = 1'b1;
                dm_run = !(div_hang || ($urandom_range(0, 99) < hang_pct));
                dm_cnt = (dm_lat_fix >= 0) ? dm_lat_fix : int'($urandom_range(0, 6));
            end
            dm_prev = div_start_o;
        end
    end

    // ------------------------------------------------- reference model
    typedef enum int {PH_FREE, PH_START, PH_RUN, PH_REPLY} phase_t;

    phase_t            ph;
    int                m_ptr, m_owner, m_wcnt;
    logic [DATA_W-1:0] m_a, m_b;
    logic [QUOT_W-1:0] m_quot, m_exp, last_quot;
    logic              m_err, last_err;
    int                grant_log[$];

    task automatic model_clear();
        ph = PH_FREE; m_ptr = 0; m_owner = 0; m_wcnt = 0;
        m_a = '0; m_b = '0; m_quot = '0; m_exp = '0; m_err = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) op_q[k].delete();
        grant_log.delete();
    endtask

    // Round-robin rule: first valid requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [DATA_W-1:0] a, b;
            bit v;
            a = DATA_W'($urandom);
            b = DATA_W'($urandom);
            v = 1'b0;
            if (op_q[k].size() > 0 && !(drop_en && $urandom_range(0, 4) == 0)) begin
                v = 1'b1;
                a = op_q[k][0].a;
                b = op_q[k][0].b;
            end
            req_valid_i[k] = v;
            req_dividend_i[k*DATA_W +: DATA_W] = a;
            req_divisor_i[k*DATA_W +: DATA_W]  = b;
            if (rsp_block > 0) rsp_ready_i[k] = !(ph == PH_REPLY && k == m_owner);
            else               rsp_ready_i[k] = rand_rsp ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (ph == PH_REPLY && rsp_block > 0) rsp_block--;
    endtask

    // Compare this cycle's outputs with the prediction, then advance the
    // prediction across the coming clock edge.
    task automatic evaluate();
        int g;
        logic [NUM_REQ-1:0] er, ev;
        g  = pick(req_valid_i, m_ptr);
        er = '0;
        if (ph == PH_FREE && g >= 0) er[g] = 1'b1;
        ev = '0;
        if (ph == PH_REPLY) ev[m_owner] = 1'b1;
        check("req_ready", 32'(req_ready_o), 32'(er));
        check("div_start", 32'(div_start_o), 32'(ph == PH_START || ph == PH_RUN));
        check("rsp_valid", 32'(rsp_valid_o), 32'(ev));
        if (ph == PH_REPLY) begin
            check("rsp_quot", 32'(rsp_quotient_o), 32'(m_quot));
            check("rsp_err", 32'(rsp_err_o), 32'(m_err));
        end
        if (ph == PH_START) begin
            check("div_dividend", 32'(div_dividend_o), 32'(m_a));
            check("div_divisor", 32'(div_divisor_o), 32'(m_b));
        end
        if (ph == PH_FREE) check("busy_in_idle", 32'(div_busy_i), 32'(0));

        case (ph)
            PH_FREE: if (g >= 0) begin
                m_owner = g;
                m_ptr   = (g + 1) % NUM_REQ;
                m_a     = op_q[g][0].a;
                m_b     = op_q[g][0].b;
                void'(op_q[g].pop_front());
                grant_log.push_back(g);
                if (m_b == 0) begin
                    m_quot = {QUOT_W{1'b1}};
                    m_err  = 1'b0;
                    ph     = PH_REPLY;
                end else begin
                    m_exp = QUOT_W'(m_a / m_b);
                    ph    = PH_START;
                end
            end
            PH_START: begin
                m_wcnt = 0;
                ph     = PH_RUN;
            end
            PH_RUN: begin
                if (div_finish_i) begin
                    m_quot = m_exp; m_err = 1'b0; ph = PH_REPLY;
                end else if (m_wcnt == TIMEOUT_CYC - 1) begin
                    m_quot = '0; m_err = 1'b1; ph = PH_REPLY;
                end else begin
                    m_wcnt++;
                end
            end
            PH_REPLY: if (rsp_ready_i[m_owner]) begin
                last_quot = m_quot;
                last_err  = m_err;
                ph        = PH_FREE;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(negedge clk_i);
        drive();
        #1;
        evaluate();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (!(ph == PH_FREE && queues_empty()) && c < budget);
        check({tag, "_done"}, 32'(ph == PH_FREE && queues_empty()), 32'(1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready_o), 32'(0));
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'(0));
        check({tag, "_rsp_quot"}, 32'(rsp_quotient_o), 32'(0));
        check({tag, "_rsp_err"}, 32'(rsp_err_o), 32'(0));
        check({tag, "_div_start"}, 32'(div_start_o), 32'(0));
        check({tag, "_div_dividend"}, 32'(div_dividend_o), 32'(0));
        check({tag, "_div_divisor"}, 32'(div_divisor_o), 32'(0));
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '0;
        model_clear();
        repeat (2) @(negedge clk_i);
        #2 reset_ni = 1'b1;
    endtask

    // -------------------------------------------------------------- sequence
    initial begin
        int s0, c;
        req_valid_i = '0; rsp_ready_i = '0;
        req_dividend_i = '0; req_divisor_i = '0;
        div_busy_i = 1'b0; div_finish_i = 1'b0; div_quotient_i = '0;
        model_clear();
        reset_ni = 1'b1;
        #1 reset_ni = 1'b0;
        #1 check_zero("por");
        repeat (2) @(negedge clk_i);
        #2 reset_ni = 1'b1;

        // Single operation, response held for a few cycles.
        s0 = dm_starts;
        push_op(0, 100, 7);
        rsp_block = 3;
        run_until_idle("single", 200);
        check("single_quot", 32'(last_quot), 32'(14));
        check("single_err", 32'(last_err), 32'(0));
        check("single_starts", 32'(dm_starts - s0), 32'(1));

        // Contention from reset: strict alternation starting with requester 0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_op(0, 20, 4);
            push_op(1, 45, 9);
        end
        run_until_idle("contend", 400);
        check("contend_nops", 32'(grant_log.size()), 32'(6));
        for (int i = 0; i < grant_log.size(); i++) check("contend_order", 32'(grant_log[i]), 32'(i % 2));
        check("contend_quot", 32'(last_quot), 32'(5));

        // Divide by zero: no divider start, immediate all-ones response.
        s0 = dm_starts;
        push_op(1, 33, 0);
        run_until_idle("dz", 50);
        check("dz_quot", 32'(last_quot), 32'h1FF);
        check("dz_err", 32'(last_err), 32'(0));
        check("dz_starts", 32'(dm_starts - s0), 32'(0));

        // Watchdog: the divider never finishes.
        div_hang = 1'b1;
        push_op(0, 50, 5);
        run_until_idle("wd", 200);
        check("wd_err", 32'(last_err), 32'(1));
        check("wd_quot", 32'(last_quot), 32'(0));
        div_hang = 1'b0;

        // Backpressure: the response is held for 10 cycles while requester 1 waits.
        push_op(0, 200, 3);
        c = 0;
        while (ph != PH_REPLY && c < 100) begin tick(); c++; end
        check("bp_reached", 32'(ph == PH_REPLY), 32'(1));
        push_op(1, 90, 10);
        rsp_block = 10;
        run_until_idle("bp", 300);
        check("bp_last_owner", 32'(grant_log[grant_log.size()-1]), 32'(1));
        check("bp_quot", 32'(last_quot), 32'(9));

        // Asynchronous reset in the middle of WAIT.
        dm_lat_fix = 20;
        push_op(0, 100, 3);
        c = 0;
        while (!(ph == PH_RUN && m_wcnt >= 3) && c < 100) begin tick(); c++; end
        check("ar_reached", 32'(ph == PH_RUN), 32'(1));
        @(posedge clk_i);
        #2 reset_ni = 1'b0;
        req_valid_i = '0;
        #1 check_zero("async");
        model_clear();
        rsp_ready_i = '0;
        repeat (2) @(negedge clk_i);
        #2 reset_ni = 1'b1;
        dm_lat_fix = -1;
        push_op(0, 255, 255);
        run_until_idle("ar_fresh", 200);
        check("ar_fresh_quot", 32'(last_quot), 32'(1));

        // Randomized traffic: request drops, response stalls, zero divisors, hangs.
        drop_en  = 1'b1;
        rand_rsp = 1'b1;
        hang_pct = 5;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 10; i++) begin
                int b;
                b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
                push_op(int'($urandom_range(0, NUM_REQ - 1)), int'($urandom_range(0, 255)), b);
            end
            run_until_idle("rand", 5000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
